// File: rtl/sdram_arbit_mc.sv
// sdram_arbit_mc: refresh-priority, round-robin arbiter of init/refresh/NUM_CH transfer engines onto one SDRAM bus
// Ports: sysclk_100M/rst clock and synchronous active-high reset; init_* init engine buses;
//        ref_req/ref_ack/ref_end/cmd_ref refresh handshake; ch_* per-channel request/grant handshake and
//        flattened command/address/bank/write-data buses (channel k at slice k); rdata registered dq;
//        grant_id current/last granted channel; CLK/CKE/cs_n/ras_n/cas_n/we_n/addr/ba/dqm/dq SDRAM pins;
//        wdog_err watchdog abort pulse.
// Optional: define SDRAM_ARB_WDOG_EN to build the REF/GRANT watchdog limited by MAX_GRANT_CYC.
module sdram_arbit_mc #(
    parameter int NUM_CH        = 4,
    parameter int ROW_W         = 13,
    parameter int BA_W          = 2,
    parameter int DQ_W          = 16,
    parameter int MAX_GRANT_CYC = 1024
) (
    input  logic                      sysclk_100M,
    input  logic                      rst,
    input  logic                      init_end_flag,
    input  logic [3:0]                cmd_init,
    input  logic [ROW_W-1:0]          addr_init,
    input  logic [BA_W-1:0]           ba_init,
    input  logic                      ref_req,
    output logic                      ref_ack,
    input  logic                      ref_end,
    input  logic [3:0]                cmd_ref,
    input  logic [NUM_CH-1:0]         ch_req,
    output logic [NUM_CH-1:0]         ch_ack,
    input  logic [NUM_CH-1:0]         ch_end,
    input  logic [NUM_CH-1:0]         ch_prech_end,
    input  logic [4*NUM_CH-1:0]       ch_cmd,
    input  logic [ROW_W*NUM_CH-1:0]   ch_addr,
    input  logic [BA_W*NUM_CH-1:0]    ch_ba,
    input  logic [NUM_CH-1:0]         ch_wr,
    input  logic [DQ_W*NUM_CH-1:0]    ch_wdata,
    output logic [DQ_W-1:0]           rdata,
    output logic [$clog2(NUM_CH)-1:0] grant_id,
    output logic                      CLK,
    output logic                      CKE,
    output logic                      cs_n,
    output logic                      ras_n,
    output logic                      cas_n,
    output logic                      we_n,
    output logic [ROW_W-1:0]          addr,
    output logic [BA_W-1:0]           ba,
    output logic [1:0]                dqm,
    inout  wire  [DQ_W-1:0]           dq,
    output logic                      wdog_err
);
    localparam int GW = $clog2(NUM_CH);
    localparam logic [3:0] NOP = 4'b0111;

    typedef enum logic [3:0] {
        INIT  = 4'b0001,
        ARBIT = 4'b0010,
        REF   = 4'b0100,
        GRANT = 4'b1000
    } state_t;

    state_t            state_q;
    logic [3:0]        cmd_q;
    logic [ROW_W-1:0]  addr_q;
    logic [BA_W-1:0]   ba_q;
    logic              ref_ack_q;
    logic [NUM_CH-1:0] ch_ack_q;
    logic [GW-1:0]     grant_id_q;
    logic [GW-1:0]     rr_q;
    logic [DQ_W-1:0]   rdata_q;
    logic [GW-1:0]     sel_d;
    logic [GW-1:0]     rr_d;
    logic [GW-1:0]     idx;
    logic              found_d;

`ifdef SDRAM_ARB_WDOG_EN
    localparam int WW = $clog2(MAX_GRANT_CYC + 1);
    logic [WW-1:0] wcnt_q;
    logic          wdog_q;
    assign wdog_err = wdog_q;
`else
    // constant 0: MAX_GRANT_CYC is always positive
    assign wdog_err = MAX_GRANT_CYC < 0;
`endif

    // first requester at or after the round-robin pointer; descending scan lets the nearest one win
    always_comb begin
        sel_d   = '0;
        found_d = 1'b0;
        idx     = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = GW'((int'(rr_q) + i) % NUM_CH);
            if (ch_req[idx]) begin
                sel_d   = idx;
                found_d = 1'b1;
            end
        end
    end

    assign rr_d = (int'(sel_d) == NUM_CH - 1) ? '0 : sel_d + 1'b1;

    always_ff @(posedge sysclk_100M) begin
        ref_ack_q <= 1'b0;
        ch_ack_q  <= '0;
        if (rst) begin
            state_q    <= INIT;
            cmd_q      <= NOP;
            addr_q     <= '0;
            ba_q       <= '0;
            grant_id_q <= '0;
            rr_q       <= '0;
            rdata_q    <= '0;
`ifdef SDRAM_ARB_WDOG_EN
            wcnt_q     <= '0;
            wdog_q     <= 1'b0;
`endif
        end else begin
            rdata_q <= dq;
            case (state_q)
                INIT: begin
                    cmd_q  <= cmd_init;
                    addr_q <= addr_init;
                    ba_q   <= ba_init;
                    if (init_end_flag) state_q <= ARBIT;
                end
                ARBIT: begin
                    cmd_q <= NOP;
                    if (ref_req) begin
                        ref_ack_q <= 1'b1;
                        state_q   <= REF;
                    end else if (found_d) begin
                        ch_ack_q   <= NUM_CH'(1) << sel_d;
                        grant_id_q <= sel_d;
                        rr_q       <= rr_d;
                        state_q    <= GRANT;
                    end
                end
                REF: begin
                    cmd_q  <= cmd_ref;
                    addr_q <= '0;
                    ba_q   <= '0;
                    if (ref_end) state_q <= ARBIT;
                end
                GRANT: begin
                    cmd_q  <= ch_cmd[4*grant_id_q +: 4];
                    addr_q <= ch_addr[ROW_W*grant_id_q +: ROW_W];
                    ba_q   <= ch_ba[BA_W*grant_id_q +: BA_W];
                    // release only once the bank is precharged, on completion or to yield to refresh
                    if (ch_prech_end[grant_id_q] && (ch_end[grant_id_q] || ref_req)) state_q <= ARBIT;
                end
                default: begin
                    state_q <= INIT;
                    cmd_q   <= NOP;
                end
            endcase
`ifdef SDRAM_ARB_WDOG_EN
            wdog_q <= 1'b0;
            if (state_q == ARBIT) wcnt_q <= '0;
            if (state_q == REF || state_q == GRANT) begin
                if (wcnt_q == WW'(MAX_GRANT_CYC - 1)) begin
                    state_q <= ARBIT;
                    cmd_q   <= NOP;
                    wdog_q  <= 1'b1;
                end else begin
                    wcnt_q <= wcnt_q + 1'b1;
                end
            end
`endif
        end
    end

    assign dq       = (state_q == GRANT && ch_wr[grant_id_q]) ? ch_wdata[DQ_W*grant_id_q +: DQ_W] : {DQ_W{1'bz}};
    assign {cs_n, ras_n, cas_n, we_n} = cmd_q;
    assign addr     = addr_q;
    assign ba       = ba_q;
    assign ref_ack  = ref_ack_q;
    assign ch_ack   = ch_ack_q;
    assign grant_id = grant_id_q;
    assign rdata    = rdata_q;
    assign CLK      = ~sysclk_100M;
    assign CKE      = 1'b1;
    assign dqm      = 2'b00;

endmodule

// File: tb/tb_sdram_arbit_mc.sv
// tb_sdram_arbit_mc: randomized self-checking bench for sdram_arbit_mc against a queue-free round-robin model
module tb_sdram_arbit_mc;
    localparam int NUM_CH = 4;
    localparam int ROW_W  = 13;
    localparam int BA_W   = 2;
    localparam int DQ_W   = 16;
    localparam int MAXC   = 16;
    localparam logic [3:0] NOP = 4'b0111;

    logic clk = 1'b0, rst = 1'b1, init_end_flag = 1'b0, ref_req = 1'b0, ref_end = 1'b0;
    logic [3:0] cmd_init = '0, cmd_ref = '0;
    logic [ROW_W-1:0] addr_init = '0;
    logic [BA_W-1:0] ba_init = '0;
    logic [NUM_CH-1:0] ch_req = '0, ch_end = '0, ch_prech_end = '0, ch_wr = '0;
    logic [4*NUM_CH-1:0] ch_cmd = '0;
    logic [ROW_W*NUM_CH-1:0] ch_addr = '0;
    logic [BA_W*NUM_CH-1:0] ch_ba = '0;
    logic [DQ_W*NUM_CH-1:0] ch_wdata = '0;
    logic tb_dq_en = 1'b0;
    logic [DQ_W-1:0] tb_dq = '0;
    logic ref_ack, CLK, CKE, cs_n, ras_n, cas_n, we_n, wdog_err;
    logic [NUM_CH-1:0] ch_ack;
    logic [DQ_W-1:0] rdata;
    logic [1:0] grant_id;
    logic [ROW_W-1:0] addr;
    logic [BA_W-1:0] ba;
    logic [1:0] dqm;
    wire [DQ_W-1:0] dq;
    wire [3:0] cmd_o = {cs_n, ras_n, cas_n, we_n};

    int checks = 0, errors = 0, rr = 0;

    assign dq = tb_dq_en ? tb_dq : {DQ_W{1'bz}};

    sdram_arbit_mc #(.NUM_CH(NUM_CH), .ROW_W(ROW_W), .BA_W(BA_W), .DQ_W(DQ_W), .MAX_GRANT_CYC(MAXC)) dut (
        .sysclk_100M(clk), .rst(rst), .init_end_flag(init_end_flag), .cmd_init(cmd_init),
        .addr_init(addr_init), .ba_init(ba_init), .ref_req(ref_req), .ref_ack(ref_ack),
        .ref_end(ref_end), .cmd_ref(cmd_ref), .ch_req(ch_req), .ch_ack(ch_ack), .ch_end(ch_end),
        .ch_prech_end(ch_prech_end), .ch_cmd(ch_cmd), .ch_addr(ch_addr), .ch_ba(ch_ba), .ch_wr(ch_wr),
        .ch_wdata(ch_wdata), .rdata(rdata), .grant_id(grant_id), .CLK(CLK), .CKE(CKE), .cs_n(cs_n),
        .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n), .addr(addr), .ba(ba), .dqm(dqm), .dq(dq),
        .wdog_err(wdog_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_bus;
        ch_cmd   = 16'($urandom);
        ch_addr  = 52'({$urandom, $urandom});
        ch_ba    = 8'($urandom);
        ch_wdata = 64'({$urandom, $urandom});
    endtask

    // reference arbitration rule: first requester at or after the pointer, wrapping
    function automatic int pick(input logic [NUM_CH-1:0] req);
        for (int i = 0; i < NUM_CH; i++)
            if (req[(rr + i) % NUM_CH]) return (rr + i) % NUM_CH;
        return -1;
    endfunction

    // one channel transaction starting from ARBIT; returns in ARBIT
    task automatic do_grant(input logic [NUM_CH-1:0] req, input int hold, input int exp);
        logic [3:0] c;
        logic [ROW_W-1:0] a;
        logic [BA_W-1:0] b;
        logic [NUM_CH-1:0] e_ack;
        e_ack = 4'(1) << exp;
        ch_req = req;
        tick;
        checks++; if (ch_ack !== e_ack) begin errors++; $display("FAIL grant_ack got %b want %b", ch_ack, e_ack); end
        checks++; if (grant_id !== 2'(exp)) begin errors++; $display("FAIL grant_id got %0d want %0d", grant_id, exp); end
        checks++; if (cmd_o !== NOP) begin errors++; $display("FAIL arbit_cmd got %b want %b", cmd_o, NOP); end
        rr = (exp + 1) % NUM_CH;
        for (int i = 0; i < hold; i++) begin
            rand_bus;
            c = ch_cmd[4*exp +: 4]; a = ch_addr[ROW_W*exp +: ROW_W]; b = ch_ba[BA_W*exp +: BA_W];
            ch_req = 4'($urandom);
            ch_end = 4'($urandom) & ~e_ack;
            ch_prech_end = 4'($urandom);
            tick;
            checks++; if (cmd_o !== c) begin errors++; $display("FAIL grant_cmd got %b want %b", cmd_o, c); end
            checks++; if (addr !== a || ba !== b) begin errors++; $display("FAIL grant_addr got %h/%h want %h/%h", addr, ba, a, b); end
            checks++; if (ch_ack !== 4'b0 || ref_ack !== 1'b0) begin errors++; $display("FAIL grant_noack got %b/%b want 0/0", ch_ack, ref_ack); end
            checks++; if (wdog_err !== 1'b0) begin errors++; $display("FAIL grant_wdog got %b want 0", wdog_err); end
        end
        rand_bus;
        c = ch_cmd[4*exp +: 4]; a = ch_addr[ROW_W*exp +: ROW_W];
        ch_end = e_ack | 4'($urandom);
        ch_prech_end = e_ack | 4'($urandom);
        tick;
        checks++; if (cmd_o !== c || addr !== a) begin errors++; $display("FAIL exit_cmd got %b/%h want %b/%h", cmd_o, addr, c, a); end
        ch_end = '0; ch_prech_end = '0; ch_req = '0;
    endtask

    // one refresh sequence starting from ARBIT with ch_req competing
    task automatic do_ref(input logic [NUM_CH-1:0] req, input int len);
        logic [3:0] c;
        ch_req = req; ref_req = 1'b1;
        tick;
        checks++; if (ref_ack !== 1'b1 || ch_ack !== 4'b0) begin errors++; $display("FAIL ref_ack got %b/%b want 1/0000", ref_ack, ch_ack); end
        checks++; if (cmd_o !== NOP) begin errors++; $display("FAIL ref_arbit_cmd got %b want %b", cmd_o, NOP); end
        ref_req = 1'b0;
        for (int i = 0; i <= len; i++) begin
            c = 4'($urandom); cmd_ref = c; ch_req = 4'($urandom);
            ref_end = (i == len);
            tick;
            checks++; if (cmd_o !== c) begin errors++; $display("FAIL ref_cmd got %b want %b", cmd_o, c); end
            checks++; if (addr !== '0 || ba !== '0) begin errors++; $display("FAIL ref_addr got %h/%h want 0/0", addr, ba); end
            checks++; if (ref_ack !== 1'b0 || ch_ack !== 4'b0) begin errors++; $display("FAIL ref_noack got %b/%b want 0/0", ref_ack, ch_ack); end
        end
        ref_end = 1'b0; ch_req = '0;
    endtask

    task automatic test_reset;
        logic [3:0] c;
        logic [ROW_W-1:0] a;
        logic [BA_W-1:0] b;
        rst = 1'b1; cmd_init = 4'b0010; addr_init = 13'h1abc; ba_init = 2'd3;
        tb_dq = 16'h1234; tb_dq_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++; if (cmd_o !== NOP) begin errors++; $display("FAIL rst_cmd got %b want %b", cmd_o, NOP); end
            checks++; if (addr !== '0 || ba !== '0) begin errors++; $display("FAIL rst_addr got %h/%h want 0/0", addr, ba); end
            checks++; if (ch_ack !== 4'b0 || ref_ack !== 1'b0 || grant_id !== 2'd0) begin errors++; $display("FAIL rst_ack got %b/%b/%0d want 0", ch_ack, ref_ack, grant_id); end
            checks++; if (rdata !== '0 || wdog_err !== 1'b0) begin errors++; $display("FAIL rst_rdata got %h/%b want 0/0", rdata, wdog_err); end
            checks++; if (dq !== 16'h1234) begin errors++; $display("FAIL rst_dq_hiz got %h want 1234", dq); end
        end
        checks++; if (CLK !== 1'b0 || CKE !== 1'b1 || dqm !== 2'b00) begin errors++; $display("FAIL pins got %b/%b/%b want 0/1/00", CLK, CKE, dqm); end
        tb_dq_en = 1'b0; rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            c = 4'($urandom); a = 13'($urandom); b = 2'($urandom);
            cmd_init = c; addr_init = a; ba_init = b;
            init_end_flag = (i == 6);
            tick;
            checks++; if (cmd_o !== c || addr !== a || ba !== b) begin errors++; $display("FAIL init_pass got %b/%h/%h want %b/%h/%h", cmd_o, addr, ba, c, a, b); end
        end
        init_end_flag = 1'b0; cmd_init = 4'($urandom); addr_init = 13'($urandom);
        tick;
        checks++; if (cmd_o !== NOP) begin errors++; $display("FAIL arbit_nop got %b want %b", cmd_o, NOP); end
        checks++; if (addr !== a || ba !== b) begin errors++; $display("FAIL arbit_hold got %h/%h want %h/%h", addr, ba, a, b); end
        checks++; if (ch_ack !== 4'b0 || ref_ack !== 1'b0) begin errors++; $display("FAIL idle_ack got %b/%b want 0/0", ch_ack, ref_ack); end
    endtask

    task automatic test_read_capture;
        tb_dq_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tb_dq = 16'($urandom);
            tick;
            checks++; if (rdata !== tb_dq) begin errors++; $display("FAIL rdata got %h want %h", rdata, tb_dq); end
            checks++; if (cmd_o !== NOP) begin errors++; $display("FAIL idle_cmd got %b want %b", cmd_o, NOP); end
        end
        tb_dq_en = 1'b0;
    endtask

    task automatic test_round_robin;
        for (int i = 0; i < 5; i++) do_grant(4'b1111, 4, i % NUM_CH);
        for (int i = 0; i < 20; i++) begin
            logic [NUM_CH-1:0] req;
            req = 4'($urandom_range(1, 15));
            do_grant(req, $urandom_range(0, 3), pick(req));
        end
    endtask

    task automatic test_ref_priority;
        do_ref(4'b1111, 2);
        do_grant(4'b1111, 1, pick(4'b1111));
        do_ref(4'b0100, 1);
        do_grant(4'b0100, 2, 2);
    endtask

    task automatic test_random_mix;
        for (int i = 0; i < 15; i++) begin
            logic [NUM_CH-1:0] req;
            req = 4'($urandom_range(1, 15));
            if ($urandom_range(0, 3) == 0) do_ref(req, $urandom_range(0, 3));
            else do_grant(req, $urandom_range(0, 3), pick(req));
        end
    endtask

    task automatic test_write_dq;
        logic [3:0] c;
        ch_req = 4'b0010;
        tick;
        checks++; if (ch_ack !== 4'b0010 || grant_id !== 2'd1) begin errors++; $display("FAIL wr_ack got %b/%0d want 0010/1", ch_ack, grant_id); end
        rr = 2; ch_req = '0;
        rand_bus;
        ch_wdata[31:16] = 16'hA5C3; ch_wr = 4'b1101;
        tb_dq = 16'h5A3C; tb_dq_en = 1'b1;
        #1;
        checks++; if (dq !== 16'h5A3C) begin errors++; $display("FAIL wr_idle_hiz got %h want 5a3c", dq); end
        tb_dq_en = 1'b0; ch_wr = 4'b1111;
        #1;
        checks++; if (dq !== 16'hA5C3) begin errors++; $display("FAIL wr_dq got %h want a5c3", dq); end
        c = ch_cmd[7:4];
        ref_req = 1'b1; ch_prech_end = 4'b0010;
        tick;
        checks++; if (rdata !== 16'hA5C3) begin errors++; $display("FAIL wr_rdata got %h want a5c3", rdata); end
        checks++; if (ref_ack !== 1'b0 || cmd_o !== c) begin errors++; $display("FAIL wr_exit got %b/%b want 0/%b", ref_ack, cmd_o, c); end
        tb_dq = 16'h5A3C; tb_dq_en = 1'b1;
        #1;
        checks++; if (dq !== 16'h5A3C) begin errors++; $display("FAIL wr_release_hiz got %h want 5a3c", dq); end
        tb_dq_en = 1'b0; ch_prech_end = '0;
        tick;
        checks++; if (ref_ack !== 1'b1 || cmd_o !== NOP) begin errors++; $display("FAIL wr_ref_ack got %b/%b want 1/%b", ref_ack, cmd_o, NOP); end
        ref_req = 1'b0; ref_end = 1'b1;
        tick;
        ref_end = 1'b0; ch_wr = '0;
    endtask

    task automatic test_reset_mid;
        logic [DQ_W-1:0] p;
        ch_req = 4'b0100;
        tick;
        checks++; if (ch_ack !== 4'b0100 || grant_id !== 2'd2) begin errors++; $display("FAIL mid_ack got %b/%0d want 0100/2", ch_ack, grant_id); end
        rr = 3; ch_req = '0;
        rand_bus; ch_wr = 4'b0100;
        tick;
        checks++; if (dq !== ch_wdata[47:32]) begin errors++; $display("FAIL mid_dq got %h want %h", dq, ch_wdata[47:32]); end
        rst = 1'b1;
        tick;
        checks++; if (cmd_o !== NOP || addr !== '0 || ba !== '0) begin errors++; $display("FAIL mid_rst_cmd got %b/%h/%h want %b/0/0", cmd_o, addr, ba, NOP); end
        checks++; if (grant_id !== 2'd0 || ch_ack !== 4'b0 || rdata !== '0) begin errors++; $display("FAIL mid_rst_regs got %0d/%b/%h want 0/0/0", grant_id, ch_ack, rdata); end
        p = 16'($urandom) & 16'hFFFE;
        ch_wdata[47:32] = ~p; tb_dq = p; tb_dq_en = 1'b1;
        #1;
        checks++; if (dq !== p) begin errors++; $display("FAIL mid_rst_hiz got %h want %h", dq, p); end
        tb_dq_en = 1'b0; rst = 1'b0; ch_wr = '0; init_end_flag = 1'b1;
        tick;
        init_end_flag = 1'b0;
        tick;
        rr = 0;
        do_grant(4'b1111, 1, 0);
    endtask

    task automatic test_watchdog;
`ifdef SDRAM_ARB_WDOG_EN
        int g, g2;
        g = pick(4'b0011);
        ch_req = 4'b0011;
        tick;
        checks++; if (ch_ack !== 4'(1) << g) begin errors++; $display("FAIL wd_ack got %b want %0d", ch_ack, g); end
        rr = (g + 1) % NUM_CH;
        for (int i = 1; i <= MAXC; i++) begin
            rand_bus;
            tick;
            checks++; if (wdog_err !== (i == MAXC)) begin errors++; $display("FAIL wd_err cycle %0d got %b want %b", i, wdog_err, i == MAXC); end
        end
        checks++; if (cmd_o !== NOP) begin errors++; $display("FAIL wd_abort_cmd got %b want %b", cmd_o, NOP); end
        g2 = pick(4'b0011);
        tick;
        checks++; if (ch_ack !== 4'(1) << g2 || wdog_err !== 1'b0) begin errors++; $display("FAIL wd_next got %b/%b want %0d/0", ch_ack, wdog_err, g2); end
        rr = (g2 + 1) % NUM_CH;
        ch_req = '0; ch_end = 4'(1) << g2; ch_prech_end = 4'(1) << g2;
        tick;
        ch_end = '0; ch_prech_end = '0;
`else
        do_grant(4'b0001, 20, 0);
`endif
    endtask

    initial begin
        test_reset;
        test_read_capture;
        test_round_robin;
        test_ref_priority;
        test_random_mix;
        test_write_dq;
        test_reset_mid;
        test_watchdog;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sdram_arbit_mc.md
Name: sdram_arbit_mc

Overview:
Parametrised multi-channel successor to the single-writer/single-reader SDRAM arbiter. It sequences one init engine, one refresh engine and NUM_CH generic transfer channels (write or read engines) onto a single SDRAM command/address/data bus. Refresh has fixed top priority; channels are served round-robin. It sits between the per-function SDRAM engines and the SDRAM pins.

Parameters:
NUM_CH, 4, number of transfer channels (2..8)
ROW_W, 13, SDRAM address bus width
BA_W, 2, bank address width
DQ_W, 16, SDRAM data width
MAX_GRANT_CYC, 1024, watchdog limit in cycles (used only with SDRAM_ARB_WDOG_EN)

Ports:
sysclk_100M  in  1  system clock; all logic on rising edge
rst  in  1  synchronous active-high reset
init_end_flag  in  1  init engine done
cmd_init / addr_init / ba_init  in  4 / ROW_W / BA_W  init engine command, address, bank
ref_req  in  1  refresh request
ref_ack  out  1  refresh grant pulse
ref_end  in  1  refresh sequence done
cmd_ref  in  4  refresh engine command
ch_req  in  NUM_CH  channel requests
ch_ack  out  NUM_CH  one-hot grant pulse
ch_end  in  NUM_CH  channel transfer complete
ch_prech_end  in  NUM_CH  channel has precharged (safe to release)
ch_cmd / ch_addr / ch_ba  in  4*NUM_CH / ROW_W*NUM_CH / BA_W*NUM_CH  flattened per-channel buses, channel k at slice k
ch_wr  in  NUM_CH  channel k drives dq this cycle
ch_wdata  in  DQ_W*NUM_CH  flattened write data
rdata  out  DQ_W  dq sampled into a register every cycle
grant_id  out  $clog2(NUM_CH)  currently or last granted channel
CLK / CKE  out  1 / 1  ~sysclk_100M / constant 1
cs_n, ras_n, cas_n, we_n  out  1 each  registered SDRAM command
addr / ba / dqm  out  ROW_W / BA_W / 2  registered address and bank; dqm constant 0
dq  inout  DQ_W  SDRAM data bus
wdog_err  out  1  watchdog abort pulse

Behaviour:
- States: INIT, ARBIT, REF, GRANT; one-hot encoding. Any illegal encoding -> INIT on the next edge.
- Reset (rst=1 at a clock edge):
  - state=INIT; {cs_n,ras_n,cas_n,we_n}=4'b0111 (NOP); addr=0, ba=0.
  - ref_ack=0, ch_ack=0, grant_id=0, RR pointer=0, rdata=0, wdog_err=0; dq hi-Z.
  - Reset mid-transfer aborts immediately with the same values.
- INIT: command/address/bank = init engine buses, registered. init_end_flag=1 -> ARBIT.
- ARBIT: command output NOP; addr/ba hold their values.
  - ref_req=1 -> ref_ack=1 for 1 cycle; next state REF.
  - Otherwise, if any ch_req: select the first requesting channel at or after the RR pointer, wrapping NUM_CH-1 -> 0.
    - ch_ack[k]=1 for 1 cycle; grant_id=k; RR pointer=k+1 mod NUM_CH; next state GRANT.
  - ref_req and ch_req in the same cycle: refresh wins; RR pointer unchanged.
  - No requests: stay in ARBIT.
- REF: command = cmd_ref; addr=0, ba=0. ref_end=1 -> ARBIT.
- GRANT: command/address/bank = channel grant_id slices, registered with 1 cycle of latency.
  - Exit to ARBIT when ch_prech_end[g]=1 && (ch_end[g]=1 || ref_req=1).
  - Changes on the granted channel's ch_req and on other channels' inputs are ignored.
- dq = ch_wdata[g] when state==GRANT && ch_wr[g]=1 (combinational); otherwise hi-Z.
- ARBIT always lasts at least 1 cycle between grants, so acks never occur back-to-back.

Optional Feature:
SDRAM_ARB_WDOG_EN
- Defined:
  - Counter clears on entry to REF/GRANT and increments each cycle in those states.
  - Counter reaching MAX_GRANT_CYC -> command NOP next cycle, state ARBIT, wdog_err=1 for 1 cycle.
  - RR pointer still advances past the aborted channel.
- Undefined: no counter is built; wdog_err is tied 0.

Test Plan:
1. rst=1 for 3 cycles, then init_end_flag=1 at cycle 10 -> outputs are NOP/addr 0 during reset; state reaches ARBIT at cycle 11; ch_ack=0.
2. ch_req=4'b1111, each channel asserts ch_prech_end+ch_end 5 cycles after its ack -> grant order 0,1,2,3,0; one ack pulse each; grant_id follows.
3. ch_req=4'b0100 and ref_req=1 in the same ARBIT cycle -> ref_ack first; after ref_end, ch_ack=4'b0100.
4. Channel 1 in GRANT with ch_wr[1]=1, ch_wdata slice 1=16'hA5C3, ref_req=1, ch_prech_end[1]=1 -> dq=16'hA5C3 while granted; ARBIT next cycle; then ref_ack.
5. Channel 2 granted, rst asserted mid-burst -> next edge: NOP, dq hi-Z, state INIT, grant_id=0.
6. With SDRAM_ARB_WDOG_EN and MAX_GRANT_CYC=16, channel 0 granted with ch_end never asserted -> wdog_err pulse after 16 GRANT cycles; channel 1's pending request is acked next.
